// File: rtl/biquad_df2t_tdm_if.sv
// ---------------------------------------------------------------------------
// biquad_df2t_tdm_if
//   Sample, coefficient and result bundle for the time-multiplexed biquad.
//
//   Sample handshake (valid/ready):
//     A sample {in_ch, x_in} transfers on a rising clock edge where in_valid
//     and in_ready are both high. The producer holds in_valid, in_ch and x_in
//     stable until that edge. in_ready never depends on in_valid. The result
//     side has no backpressure: out_valid is a one-cycle strobe, and
//     out_ch/y_out/out_sat hold their values until the next result.
//
//   Signals:
//     in_valid/in_ready/in_ch/x_in     sample offer and accept
//     cfg_we/cfg_clr/cfg_ch/cfg_sel/cfg_data
//                                      coefficient write and state clear
//     out_valid/out_ch/y_out/out_sat   result strobe, channel, value, clip flag
//
//   Modports: master drives samples/config (source side), slave is the filter.
// ---------------------------------------------------------------------------
interface biquad_df2t_tdm_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int CH_BITS     = 2
);
  logic                          in_valid;
  logic                          in_ready;
  logic        [CH_BITS-1:0]     in_ch;
  logic signed [DATA_WIDTH-1:0]  x_in;

  logic                          cfg_we;
  logic                          cfg_clr;
  logic        [CH_BITS-1:0]     cfg_ch;
  logic        [2:0]             cfg_sel;
  logic signed [COEFF_WIDTH-1:0] cfg_data;

  logic                          out_valid;
  logic        [CH_BITS-1:0]     out_ch;
  logic signed [DATA_WIDTH-1:0]  y_out;
  logic                          out_sat;

  modport master (
    output in_valid, in_ch, x_in,
    output cfg_we, cfg_clr, cfg_ch, cfg_sel, cfg_data,
    input  in_ready, out_valid, out_ch, y_out, out_sat
  );

  modport slave (
    input  in_valid, in_ch, x_in,
    input  cfg_we, cfg_clr, cfg_ch, cfg_sel, cfg_data,
    output in_ready, out_valid, out_ch, y_out, out_sat
  );
endinterface

// File: rtl/biquad_df2t_tdm.sv
// ---------------------------------------------------------------------------
// biquad_df2t_tdm
//   Transposed direct-form-II biquad shared by NUM_CH channels. One sample is
//   processed at a time through IDLE -> MUL -> ACC -> OUT; each channel owns
//   its s1/s2 state and a five-entry coefficient bank (b0 b1 b2 a1 a2).
//   Output is rounded half-up from FRAC_BITS and saturated to DATA_WIDTH.
//
//   Ports:
//     clk          rising-edge clock
//     rst          synchronous active-high reset
//     bus          biquad_df2t_tdm_if.slave (samples, config, results)
//     dbg_state_o  current FSM state (0 IDLE, 1 MUL, 2 ACC, 3 OUT)
// ---------------------------------------------------------------------------
module biquad_df2t_tdm #(
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int FRAC_BITS   = 14,
  parameter int NUM_CH      = 4,
  parameter int CH_BITS     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  biquad_df2t_tdm_if.slave       bus,
  output logic [1:0]             dbg_state_o
);
  localparam int ACC_W = DATA_WIDTH + COEFF_WIDTH + 2;

  // Rounding constant and clip limits, held one bit wider than the
  // accumulator so the half-up add cannot wrap.
  localparam logic signed [ACC_W:0] RND   = (ACC_W+1)'(1) << (FRAC_BITS-1);
  localparam logic signed [ACC_W:0] Y_MAX = ((ACC_W+1)'(1) << (DATA_WIDTH-1)) - (ACC_W+1)'(1);
  localparam logic signed [ACC_W:0] Y_MIN = ~Y_MAX;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_ACC  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t state_q;

  // Per-channel coefficient banks (index 0..4 = b0 b1 b2 a1 a2) and state.
  logic signed [COEFF_WIDTH-1:0] coef_q [NUM_CH][5];
  logic signed [ACC_W-1:0]       s1_q   [NUM_CH];
  logic signed [ACC_W-1:0]       s2_q   [NUM_CH];

  // In-flight sample: input, channel and coefficient snapshot.
  logic signed [DATA_WIDTH-1:0]  x_q;
  logic        [CH_BITS-1:0]     ch_q;
  logic                          ch_ok_q;
  logic signed [COEFF_WIDTH-1:0] b0_q, b1_q, b2_q, a1_q, a2_q;

  // Pipeline registers.
  logic signed [ACC_W-1:0]       p0_q, p1_q, p2_q, s1r_q, s2r_q;
  logic signed [DATA_WIDTH-1:0]  y_q;
  logic                          sat_q;

  // Registered outputs.
  logic                          out_valid_q;
  logic        [CH_BITS-1:0]     out_ch_q;
  logic signed [DATA_WIDTH-1:0]  y_out_q;
  logic                          out_sat_q;

  logic in_ready;
  logic accept;

  assign in_ready = (state_q == S_IDLE) && !rst;
  assign accept   = bus.in_valid && in_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.y_out     = y_out_q;
  assign bus.out_sat   = out_sat_q;
  assign dbg_state_o   = state_q;

  // Channel lookups. Loops compare against each implemented channel so an
  // index beyond NUM_CH simply matches nothing and reads zero.
  logic                          in_ch_ok;
  logic signed [COEFF_WIDTH-1:0] in_b0, in_b1, in_b2, in_a1, in_a2;
  logic signed [ACC_W-1:0]       s1_cur, s2_cur;

  always_comb begin
    in_ch_ok = 1'b0;
    in_b0    = '0;
    in_b1    = '0;
    in_b2    = '0;
    in_a1    = '0;
    in_a2    = '0;
    s1_cur   = '0;
    s2_cur   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (bus.in_ch == CH_BITS'(k)) begin
        in_ch_ok = 1'b1;
        in_b0    = coef_q[k][0];
        in_b1    = coef_q[k][1];
        in_b2    = coef_q[k][2];
        in_a1    = coef_q[k][3];
        in_a2    = coef_q[k][4];
      end
      if (ch_q == CH_BITS'(k)) begin
        s1_cur = s1_q[k];
        s2_cur = s2_q[k];
      end
    end
  end

  // Sign-extended operands; all products are formed at ACC_W and wrap.
  logic signed [ACC_W-1:0] x_ext, b0_ext, b1_ext, b2_ext, a1_ext, a2_ext, y_ext;

  assign x_ext  = {{(ACC_W-DATA_WIDTH){x_q[DATA_WIDTH-1]}}, x_q};
  assign y_ext  = {{(ACC_W-DATA_WIDTH){y_q[DATA_WIDTH-1]}}, y_q};
  assign b0_ext = {{(ACC_W-COEFF_WIDTH){b0_q[COEFF_WIDTH-1]}}, b0_q};
  assign b1_ext = {{(ACC_W-COEFF_WIDTH){b1_q[COEFF_WIDTH-1]}}, b1_q};
  assign b2_ext = {{(ACC_W-COEFF_WIDTH){b2_q[COEFF_WIDTH-1]}}, b2_q};
  assign a1_ext = {{(ACC_W-COEFF_WIDTH){a1_q[COEFF_WIDTH-1]}}, a1_q};
  assign a2_ext = {{(ACC_W-COEFF_WIDTH){a2_q[COEFF_WIDTH-1]}}, a2_q};

  logic signed [ACC_W-1:0] mul_p0, mul_p1, mul_p2;
  assign mul_p0 = b0_ext * x_ext;
  assign mul_p1 = b1_ext * x_ext;
  assign mul_p2 = b2_ext * x_ext;

  // ACC stage: accumulate, round half-up, clip.
  logic signed [ACC_W-1:0]      y_acc;
  logic signed [ACC_W:0]        y_sum;
  logic signed [ACC_W:0]        y_shift;
  logic signed [DATA_WIDTH-1:0] y_d;
  logic                         sat_d;

  assign y_acc   = p0_q + s1r_q;
  assign y_sum   = {y_acc[ACC_W-1], y_acc} + RND;
  assign y_shift = y_sum >>> FRAC_BITS;

  always_comb begin
    y_d   = y_shift[DATA_WIDTH-1:0];
    sat_d = 1'b0;
    if (y_shift > Y_MAX) begin
      y_d   = Y_MAX[DATA_WIDTH-1:0];
      sat_d = 1'b1;
    end else if (y_shift < Y_MIN) begin
      y_d   = Y_MIN[DATA_WIDTH-1:0];
      sat_d = 1'b1;
    end
  end

  // OUT stage: state update uses the saturated y, not the raw accumulator.
  logic signed [ACC_W-1:0] s1_new, s2_new;
  assign s1_new = p1_q - a1_ext * y_ext + s2r_q;
  assign s2_new = p2_q - a2_ext * y_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      for (int k = 0; k < NUM_CH; k++) begin
        s1_q[k] <= '0;
        s2_q[k] <= '0;
        for (int j = 0; j < 5; j++) coef_q[k][j] <= '0;
      end
      x_q         <= '0;
      ch_q        <= '0;
      ch_ok_q     <= 1'b0;
      b0_q        <= '0;
      b1_q        <= '0;
      b2_q        <= '0;
      a1_q        <= '0;
      a2_q        <= '0;
      p0_q        <= '0;
      p1_q        <= '0;
      p2_q        <= '0;
      s1r_q       <= '0;
      s2r_q       <= '0;
      y_q         <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      y_out_q     <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      // Coefficient writes land in the bank only; the in-flight snapshot
      // is untouched until the next accept.
      for (int k = 0; k < NUM_CH; k++) begin
        for (int j = 0; j < 5; j++) begin
          if (bus.cfg_we && bus.cfg_ch == CH_BITS'(k) && bus.cfg_sel == 3'(j)) begin
            coef_q[k][j] <= bus.cfg_data;
          end
        end
      end

      out_valid_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (accept) begin
            x_q     <= bus.x_in;
            ch_q    <= bus.in_ch;
            ch_ok_q <= in_ch_ok;
            b0_q    <= in_b0;
            b1_q    <= in_b1;
            b2_q    <= in_b2;
            a1_q    <= in_a1;
            a2_q    <= in_a2;
            state_q <= S_MUL;
          end
        end
        S_MUL: begin
          p0_q    <= mul_p0;
          p1_q    <= mul_p1;
          p2_q    <= mul_p2;
          s1r_q   <= s1_cur;
          s2r_q   <= s2_cur;
          state_q <= S_ACC;
        end
        S_ACC: begin
          y_q     <= y_d;
          sat_q   <= sat_d;
          state_q <= S_OUT;
        end
        S_OUT: begin
          state_q <= S_IDLE;
          // Samples for unimplemented channels cycle through silently.
          if (ch_ok_q) begin
            out_valid_q <= 1'b1;
            out_ch_q    <= ch_q;
            y_out_q     <= y_q;
            out_sat_q   <= sat_q;
            for (int k = 0; k < NUM_CH; k++) begin
              if (ch_q == CH_BITS'(k)) begin
                s1_q[k] <= s1_new;
                s2_q[k] <= s2_new;
              end
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // Placed after the OUT update so a same-edge clear overrides it.
      for (int k = 0; k < NUM_CH; k++) begin
        if (bus.cfg_clr && bus.cfg_ch == CH_BITS'(k)) begin
          s1_q[k] <= '0;
          s2_q[k] <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_biquad_df2t_tdm.sv
module tb_biquad_df2t_tdm;
  localparam int DW  = 16;
  localparam int CW  = 16;
  localparam int FB  = 14;
  localparam int NCH = 3;
  localparam int CB  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  biquad_df2t_tdm_if #(.DATA_WIDTH(DW), .COEFF_WIDTH(CW), .CH_BITS(CB)) bus ();
  logic [1:0] dbg_state;

  biquad_df2t_tdm #(
    .DATA_WIDTH(DW), .COEFF_WIDTH(CW), .FRAC_BITS(FB), .NUM_CH(NCH), .CH_BITS(CB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .dbg_state_o(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // ---------------- scoreboard ----------------
  // Entry: {sat, ch, y}; exp_t_q holds the cycle count at which it must appear.
  logic [DW+CB:0] exp_q[$];
  int             exp_t_q[$];
  int             acc_cycles[$];

  logic [DW-1:0]  cur_y       = '0;
  logic           cur_sat     = 1'b0;
  logic           cur_discard = 1'b1;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.in_valid && bus.in_ready) begin
      acc_cycles.push_back(cyc);
      if (!cur_discard) begin
        exp_q.push_back({cur_sat, bus.in_ch, cur_y});
        exp_t_q.push_back(cyc + 4);
      end
    end
  end

  always @(negedge clk) begin
    logic [DW+CB:0] e;
    int             t;
    if (bus.out_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out_valid ch=%0d y=%0d", bus.out_ch, $signed(bus.y_out));
      end else begin
        e = exp_q.pop_front();
        t = exp_t_q.pop_front();
        checks++;
        if (bus.y_out !== e[DW-1:0]) begin
          errors++;
          $display("FAIL y_out ch=%0d got=%0d exp=%0d", e[DW+CB-1:DW],
                   $signed(bus.y_out), $signed(e[DW-1:0]));
        end
        checks++;
        if (bus.out_ch !== e[DW+CB-1:DW]) begin
          errors++;
          $display("FAIL out_ch got=%0d exp=%0d", bus.out_ch, e[DW+CB-1:DW]);
        end
        checks++;
        if (bus.out_sat !== e[DW+CB]) begin
          errors++;
          $display("FAIL out_sat got=%0b exp=%0b", bus.out_sat, e[DW+CB]);
        end
        checks++;
        if (cyc != t) begin
          errors++;
          $display("FAIL latency got_cycle=%0d exp_cycle=%0d", cyc, t);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int ch, input int sel, input int data);
    bus.cfg_we   = 1'b1;
    bus.cfg_ch   = CB'(ch);
    bus.cfg_sel  = 3'(sel);
    bus.cfg_data = CW'(data);
    tick();
    bus.cfg_we   = 1'b0;
  endtask

  task automatic cfg_clear(input int ch);
    bus.cfg_clr = 1'b1;
    bus.cfg_ch  = CB'(ch);
    tick();
    bus.cfg_clr = 1'b0;
  endtask

  // Offers one sample and returns at #1 after the accepting edge.
  task automatic send(input int ch, input int x, input int ey, input bit esat, input bit disc);
    bit took;
    cur_y       = DW'(ey);
    cur_sat     = esat;
    cur_discard = disc;
    bus.in_ch   = CB'(ch);
    bus.x_in    = DW'(x);
    bus.in_valid = 1'b1;
    took = 1'b0;
    for (int i = 0; i < 20 && !took; i++) begin
      took = bus.in_ready;
      tick();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (!took) begin
      errors++;
      $display("FAIL send_accept ch=%0d x=%0d got=not_accepted exp=accepted", ch, x);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d exp=0", exp_q.size());
    end
    tick();
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
    checks++; if (bus.y_out !== '0) begin errors++; $display("FAIL reset_y_out got=%0d exp=0", $signed(bus.y_out)); end
    checks++; if (bus.out_ch !== '0) begin errors++; $display("FAIL reset_out_ch got=%0d exp=0", bus.out_ch); end
    checks++; if (bus.out_sat !== 1'b0) begin errors++; $display("FAIL reset_out_sat got=%0b exp=0", bus.out_sat); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low got=%0b exp=0", bus.in_ready); end
    rst = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_high got=%0b exp=1", bus.in_ready); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    tick();
  endtask

  task automatic test_passthrough();
    cfg_write(0, 0, 16384);
    send(0, 1000, 1000, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_recursion();
    cfg_write(1, 0, 16384);
    cfg_write(1, 3, -8192);
    send(1, 1000, 1000, 1'b0, 1'b0);
    send(1, 0, 500, 1'b0, 1'b0);
    send(1, 0, 250, 1'b0, 1'b0);
    send(1, 0, 125, 1'b0, 1'b0);
    send(1, 0, 63, 1'b0, 1'b0);
    drain();
    cfg_clear(1);
    send(1, 0, 0, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_isolation();
    cfg_write(2, 0, 8192);
    cfg_write(2, 3, -8192);
    send(2, 400, 200, 1'b0, 1'b0);
    send(0, 400, 400, 1'b0, 1'b0);
    send(2, 0, 100, 1'b0, 1'b0);
    send(0, 400, 400, 1'b0, 1'b0);
    send(2, 0, 50, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_saturation();
    cfg_write(0, 0, 32767);
    send(0, 30000, 32767, 1'b1, 1'b0);
    send(0, -30000, -32768, 1'b1, 1'b0);
    drain();
    cfg_write(0, 0, 8192);
    send(0, -5, -2, 1'b0, 1'b0);
    send(0, -3, -1, 1'b0, 1'b0);
    send(0, 3, 2, 1'b0, 1'b0);
    send(0, 5, 3, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_invalid_channel();
    // ch1 still has b0=0.5*2, a1=-0.5 and zero state after the clear.
    send(1, 1000, 1000, 1'b0, 1'b0);
    send(3, 5000, 0, 1'b0, 1'b1);
    send(1, 0, 500, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_back_to_back();
    int x;
    cfg_write(0, 0, 16384);
    acc_cycles.delete();
    bus.in_ch    = '0;
    cur_sat      = 1'b0;
    cur_discard  = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      x = int'($urandom_range(0, 40000)) - 20000;
      bus.x_in = DW'(x);
      cur_y    = DW'(x);
      tick();
    end
    bus.in_valid = 1'b0;
    cur_discard  = 1'b1;
    drain();
    checks++;
    if (acc_cycles.size() != 10) begin
      errors++;
      $display("FAIL b2b_accept_count got=%0d exp=10", acc_cycles.size());
    end
    for (int i = 1; i < acc_cycles.size(); i++) begin
      checks++;
      if (acc_cycles[i] - acc_cycles[i-1] != 4) begin
        errors++;
        $display("FAIL b2b_accept_gap idx=%0d got=%0d exp=4", i, acc_cycles[i] - acc_cycles[i-1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    // ch1 state after the previous test makes the next zero input give 250.
    send(1, 0, 250, 1'b0, 1'b0);
    drain();
    send(1, 777, 0, 1'b0, 1'b1);
    tick();
    checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL midrst_in_acc got=%0d exp=2", dbg_state); end
    rst = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready got=%0b exp=0", bus.in_ready); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%0b exp=0", bus.out_valid); end
    checks++; if (bus.y_out !== '0) begin errors++; $display("FAIL midrst_y_out got=%0d exp=0", $signed(bus.y_out)); end
    checks++; if (bus.out_ch !== '0) begin errors++; $display("FAIL midrst_out_ch got=%0d exp=0", bus.out_ch); end
    checks++; if (bus.out_sat !== 1'b0) begin errors++; $display("FAIL midrst_out_sat got=%0b exp=0", bus.out_sat); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL midrst_state got=%0d exp=0", dbg_state); end
    tick();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready_hold got=%0b exp=0", bus.in_ready); end
    rst = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready_release got=%0b exp=1", bus.in_ready); end
    tick();
    repeat (4) tick();
    // Coefficients and state were cleared, so ch1 now outputs zero.
    send(1, 1000, 0, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_cfg_midflight();
    cfg_write(0, 0, 16384);
    send(0, 1000, 1000, 1'b0, 1'b0);
    checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL midcfg_in_mul got=%0d exp=1", dbg_state); end
    cfg_write(0, 0, 8192);
    send(0, 1000, 500, 1'b0, 1'b0);
    drain();
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    bus.in_valid = 1'b0;
    bus.in_ch    = '0;
    bus.x_in     = '0;
    bus.cfg_we   = 1'b0;
    bus.cfg_clr  = 1'b0;
    bus.cfg_ch   = '0;
    bus.cfg_sel  = '0;
    bus.cfg_data = '0;

    test_reset();
    test_passthrough();
    test_recursion();
    test_isolation();
    test_saturation();
    test_invalid_channel();
    test_back_to_back();
    test_reset_mid();
    test_cfg_midflight();

    repeat (6) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_queue pending=%0d exp=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t", $time);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/biquad_df2t_tdm.md
# biquad_df2t_tdm

Time-multiplexed, multi-channel transposed direct-form-II biquad section with a valid/ready sample interface, per-channel coefficient banks, rounding and output saturation. One shared multiply/accumulate datapath serves NUM_CH independent channels. Each channel keeps its own s1/s2 state. The block sits in the IIR filter chain wherever several streams must share one biquad stage. It replaces the single-channel free-running section.

## Interface
- DATA_WIDTH, 16, sample width, signed two's complement
- COEFF_WIDTH, 16, coefficient width, signed
- FRAC_BITS, 14, coefficient fractional bits (Q2.14 by default); 1 ≤ FRAC_BITS < COEFF_WIDTH
- NUM_CH, 4, number of channels; 1 ≤ NUM_CH ≤ 2^CH_BITS
- CH_BITS, 2, channel-index width
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  sample offered
- in_ready  out  1  block can accept; high only in IDLE and only when rst=0
- in_ch  in  CH_BITS  channel of offered sample
- x_in  in  DATA_WIDTH  sample
- cfg_we  in  1  coefficient write strobe
- cfg_clr  in  1  clear s1/s2 of channel cfg_ch
- cfg_ch  in  CH_BITS  target channel for cfg_we/cfg_clr
- cfg_sel  in  3  0=b0, 1=b1, 2=b2, 3=a1, 4=a2; 5–7 ignored
- cfg_data  in  COEFF_WIDTH  coefficient value
- out_valid  out  1  one-cycle result strobe, no backpressure
- out_ch  out  CH_BITS  channel of result
- y_out  out  DATA_WIDTH  result
- out_sat  out  1  y_out was clipped (qualified by out_valid)

## Operation
- ACC_W = DATA_WIDTH+COEFF_WIDTH+2. All products, s1, s2 and y_acc are ACC_W signed. State arithmetic wraps modulo 2^ACC_W.
- FSM states: IDLE → MUL → ACC → OUT → IDLE. Each transition is unconditional except IDLE→MUL, which requires in_valid & in_ready.
- Accept edge (IDLE):
  - latch x_in and in_ch;
  - snapshot the five coefficients of in_ch;
  - if in_ch ≥ NUM_CH, the sample is still accepted and the FSM still cycles, but the result is discarded: no out_valid and no state update.
- MUL: form the products b0·x, b1·x, b2·x. Read s1 and s2 of the channel.
- ACC:
  - y_acc = b0·x + s1;
  - y_r = (y_acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS (round half up, arithmetic shift);
  - y = y_r clipped to [−2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)−1]; sat = clip occurred.
- OUT edge:
  - s1 ← b1·x − a1·y + s2;
  - s2 ← b2·x − a2·y;
  - y is the saturated output, sign-extended to ACC_W before the multiply;
  - y_out ← y, out_ch ← ch, out_sat ← sat, out_valid ← 1.
- out_valid is 0 in every other cycle. y_out, out_ch and out_sat hold their values until the next result.
- Coefficient write: bank[cfg_ch][cfg_sel] ← cfg_data at the edge where cfg_we=1, in any FSM state. Samples accepted at a later edge use the new value. An in-flight sample keeps its snapshot. Writes with cfg_ch ≥ NUM_CH or cfg_sel ≥ 5 are ignored.
- Clear: cfg_clr=1 zeroes s1/s2 of cfg_ch at that edge. If it coincides with the OUT update of the same channel, the clear wins.
- Reset (rst=1 at an edge, any state):
  - FSM → IDLE;
  - all s1/s2 → 0, all coefficients → 0, snapshots → 0;
  - out_valid → 0, y_out → 0, out_ch → 0, out_sat → 0.
  - An in-flight sample is dropped and produces no out_valid.

## Timing
- Latency: for a sample accepted at edge E, out_valid is registered at edge E+3 and is high during cycle E+3..E+4.
- in_ready returns high in that same cycle. Maximum throughput is one sample per 4 cycles.
- in_ready is combinational from FSM state and rst. in_valid may be held high; a sample is consumed only on an edge where in_valid & in_ready are both high.
- Coefficient and clear writes have 1-edge effect and never stall the FSM.
- Channels are fully independent: a sample on channel k touches only channel k's s1/s2.

## Test plan
- Passthrough: ch0 b0=16384, others 0. x=1000 → y_out=1000, out_ch=0, out_valid exactly 3 edges after accept, out_sat=0.
- Recursion:
  - ch1 b0=16384, a1=−8192. Impulse x=1000, then zeros → 1000, 500, 250, 125, 63 (half-up rounding).
  - cfg_clr on ch1 → next zero input yields 0.
- Channel isolation: ch0 passthrough, ch2 gain b0=8192. Interleave ch0 x=400 and ch2 x=400 → 400 and 200 alternating. ch2's recursion is unaffected by ch0 traffic.
- Saturation and rounding:
  - b0=32767, x=30000 → y_out=32767, out_sat=1;
  - x=−30000 → −32768, out_sat=1;
  - b0=8192, x=−5 → −2.
- Handshake stress:
  - in_valid held high with a new x every cycle → accepts exactly every 4th edge;
  - in_ch=3 with NUM_CH=3 → no out_valid and no state change.
- Reset and mid-operation writes:
  - rst asserted in ACC → no out_valid, all outputs 0, in_ready 0 while rst=1, then 1.
  - A b0 write during MUL does not alter the in-flight result but applies to the next sample.
